mem_writeback: RTL

MEM_WRITEBACK -- requirements
Module: mem_writeback

---
 rtl/mem_writeback_pkg.sv | 16 +
 rtl/mem_writeback_timeout.sv | 25 ++
 rtl/mem_writeback.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_writeback_pkg.sv
// rtl/mem_writeback_pkg.sv - shared memwrite encodings and writeback state enumeration
package mem_writeback_pkg;

    typedef enum logic [1:0] {
        MW_NONE  = 2'b00,
        MW_LOAD  = 2'b01,
        MW_STORE = 2'b10,
        MW_RSVD  = 2'b11
    } memwrite_t;

    typedef enum logic {
        IDLE    = 1'b0,
        MEMWAIT = 1'b1
    } wb_state_t;

endpackage

// File: rtl/mem_writeback_timeout.sv
// rtl/mem_writeback_timeout.sv - MEMWAIT wait counter with terminal-count compare (module wb_timeout)
module wb_timeout #(
    parameter int TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_last
);

    logic [7:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_count <= 8'd0;
        end else if (i_inc) begin
            r_count <= r_count + 8'd1;
        end
    end

    // High during the TIMEOUT-th consecutive wait cycle; an ack in that cycle still wins.
    assign o_last = (r_count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_writeback.sv
// rtl/mem_writeback.sv - writeback stage: ALU results direct, loads/stores through a timed memory handshake
module mem_writeback
    import mem_writeback_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        writereg,
    input  logic [1:0]  memwrite,
    input  logic [2:0]  regaddress,
    input  logic [15:0] address,
    input  logic [15:0] storedata,
    input  logic [15:0] aluresult,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        writeflag,
    output logic [2:0]  writetarget,
    output logic [15:0] writeval,
    output logic        mem_error
);

    wb_state_t   r_state;
    wb_state_t   w_state_next;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic        r_writeflag;
    logic [2:0]  r_writetarget;
    logic [15:0] r_writeval;
    logic        r_mem_error;
    logic        r_pend_wr;
    logic [2:0]  r_pend_reg;

    logic w_accept;
    logic w_is_mem;
    logic w_ack;
    logic w_last;
    logic w_timeout;

    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_is_mem  = (memwrite == MW_LOAD) || (memwrite == MW_STORE);
    // mem_req is high for the whole of MEMWAIT, so the state alone qualifies ack.
    assign w_ack     = (r_state == MEMWAIT) && mem_ack;
    assign w_timeout = (r_state == MEMWAIT) && !mem_ack && w_last;

    wb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .i_clear (w_accept && w_is_mem),
        .i_inc   ((r_state == MEMWAIT) && !mem_ack),
        .o_last  (w_last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept && w_is_mem) w_state_next = MEMWAIT;
            MEMWAIT: if (w_ack || w_timeout)   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= 16'd0;
            r_mem_wdata   <= 16'd0;
            r_writeflag   <= 1'b0;
            r_writetarget <= 3'd0;
            r_writeval    <= 16'd0;
            r_mem_error   <= 1'b0;
            r_pend_wr     <= 1'b0;
            r_pend_reg    <= 3'd0;
        end else begin
            r_writeflag <= 1'b0;
            if (w_accept) begin
                if (memwrite == MW_NONE) begin
                    r_writeflag <= writereg;
                    if (writereg) begin
                        r_writetarget <= regaddress;
                        r_writeval    <= aluresult;
                    end
                end else if (w_is_mem) begin
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= (memwrite == MW_STORE);
                    r_mem_addr  <= address;
                    r_mem_wdata <= storedata;
                    r_pend_wr   <= writereg && (memwrite == MW_LOAD);
                    r_pend_reg  <= regaddress;
                end
            end
            if (w_ack) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
                if (r_pend_wr) begin
                    r_writeflag   <= 1'b1;
                    r_writetarget <= r_pend_reg;
                    r_writeval    <= mem_rdata;
                end
            end
            if (w_timeout) begin
                r_mem_req   <= 1'b0;
                r_mem_we    <= 1'b0;
                r_mem_error <= 1'b1;
            end
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign writeflag   = r_writeflag;
    assign writetarget = r_writetarget;
    assign writeval    = r_writeval;
    assign mem_error   = r_mem_error;

endmodule
